// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I/RV32M control path.
// Holds opcode/funct constants, alu_op codes (5 bits wide so RV32M fits),
// wb_sel/imm_type codes, the legacy 8-bit control-bundle layout and the
// registered control struct used by the pipeline stage.
package decode_pkg;

  // Major opcodes (full 7 bits, bits[1:0] always 11)
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  // alu_op codes
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_LUI    = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_U = 3'b000,
    IMM_J = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_I = 3'b100
  } imm_type_e;

  // Legacy bundle layout: reg_write | wb_sel[1:0] | rs1_pc | rs2_imm | imm_type[2:0]
  localparam int BIT_REG_WRITE = 7;
  localparam int WB_SEL_HI     = 6;
  localparam int WB_SEL_LO     = 5;
  localparam int BIT_RS1_PC    = 4;
  localparam int BIT_RS2_IMM   = 3;
  localparam int IMM_HI        = 2;
  localparam int IMM_LO        = 0;

  localparam logic [7:0] BUNDLE_LOAD   = 8'b1_01_0_1_100;
  localparam logic [7:0] BUNDLE_STORE  = 8'b0_00_0_1_010;
  localparam logic [7:0] BUNDLE_OP     = 8'b1_00_0_0_000;
  localparam logic [7:0] BUNDLE_OP_IMM = 8'b1_00_0_1_100;
  localparam logic [7:0] BUNDLE_BRANCH = 8'b0_00_1_1_011;
  localparam logic [7:0] BUNDLE_JALR   = 8'b1_10_0_1_100;
  localparam logic [7:0] BUNDLE_JAL    = 8'b1_10_1_1_001;
  localparam logic [7:0] BUNDLE_LUI    = 8'b1_00_0_1_000;
  localparam logic [7:0] BUNDLE_AUIPC  = 8'b1_00_1_1_000;

  typedef struct packed {
    logic      regWrite;
    wb_sel_e   wbSel;
    logic      rs1PcSel;
    logic      rs2ImmSel;
    imm_type_e immType;
    logic      isBranch;
    logic      isLoad;
    logic      isStore;
    logic      uncondBranch;
    logic      isMuldiv;
    logic [4:0] aluOp;
    logic      illegal;
  } ctrl_t;

  // funct3 -> alu_op for the shared R/I arithmetic group (base variant)
  function automatic logic [4:0] baseAluOp(input logic [2:0] funct3);
    case (funct3)
      3'b000:  baseAluOp = ALU_ADD;
      3'b001:  baseAluOp = ALU_SLL;
      3'b010:  baseAluOp = ALU_SLT;
      3'b011:  baseAluOp = ALU_SLTU;
      3'b100:  baseAluOp = ALU_XOR;
      3'b101:  baseAluOp = ALU_SRL;
      3'b110:  baseAluOp = ALU_OR;
      default: baseAluOp = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I (+ optional RV32M) instruction decoder.
// Ports:
//   instr_i  - 32-bit instruction word
//   ctrl_o   - decoded control struct (all-zero except illegal on a bad word)
//   rd_o, rs1_o, rs2_o - raw register index fields
module instr_decoder
  import decode_pkg::*;
#(
  parameter bit M_EXT = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [7:0] bundle;
  ctrl_t      ctrl;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign rd_o  = instr_i[11:7];
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];

  // Each opcode picks its legacy bundle and sets class flags / alu_op.
  // An illegal word collapses to an all-zero bundle with only illegal set,
  // so downstream never sees a partial write or class flag for a trap.
  always_comb begin
    bundle = '0;
    ctrl   = '0;
    case (opcode)
      OPC_LOAD: begin
        bundle       = BUNDLE_LOAD;
        ctrl.isLoad  = 1'b1;
        ctrl.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        bundle       = BUNDLE_STORE;
        ctrl.isStore = 1'b1;
        ctrl.illegal = (funct3 >= 3'b011);
      end
      OPC_OP: begin
        bundle = BUNDLE_OP;
        case (funct7)
          F7_BASE: ctrl.aluOp = baseAluOp(funct3);
          F7_ALT: begin
            if (funct3 == F3_ADD_SUB) begin
              ctrl.aluOp = ALU_SUB;
            end else if (funct3 == F3_SR) begin
              ctrl.aluOp = ALU_SRA;
            end else begin
              ctrl.illegal = 1'b1;
            end
          end
          F7_MULDIV: begin
            if (M_EXT) begin
              ctrl.isMuldiv = 1'b1;
              ctrl.aluOp    = ALU_MUL + {2'b00, funct3};
            end else begin
              ctrl.illegal = 1'b1;
            end
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        bundle     = BUNDLE_OP_IMM;
        ctrl.aluOp = baseAluOp(funct3);
        // Only shifts interpret the upper immediate bits as funct7
        if (funct3 == F3_SLL) begin
          ctrl.illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT) begin
            ctrl.aluOp = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            ctrl.illegal = 1'b1;
          end
        end
      end
      OPC_BRANCH: begin
        bundle        = BUNDLE_BRANCH;
        ctrl.isBranch = 1'b1;
        ctrl.illegal  = (funct3[2:1] == 2'b01);
      end
      OPC_JALR: begin
        bundle            = BUNDLE_JALR;
        ctrl.uncondBranch = 1'b1;
        ctrl.illegal      = (funct3 != 3'b000);
      end
      OPC_JAL: begin
        bundle            = BUNDLE_JAL;
        ctrl.uncondBranch = 1'b1;
      end
      OPC_LUI: begin
        bundle     = BUNDLE_LUI;
        ctrl.aluOp = ALU_LUI;
      end
      OPC_AUIPC: begin
        bundle = BUNDLE_AUIPC;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    ctrl.regWrite  = bundle[BIT_REG_WRITE];
    ctrl.wbSel     = wb_sel_e'(bundle[WB_SEL_HI:WB_SEL_LO]);
    ctrl.rs1PcSel  = bundle[BIT_RS1_PC];
    ctrl.rs2ImmSel = bundle[BIT_RS2_IMM];
    ctrl.immType   = imm_type_e'(bundle[IMM_HI:IMM_LO]);

    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: decodes instr_i and holds the control bundle in
// the ID/EX register with a valid/ready handshake, flush, and a busy counter
// that blocks issue while a multi-cycle MUL/DIV occupies execute.
// Ports:
//   clk_i, rst_ni                 - clock, async active-low reset
//   instr_i, instr_valid_i        - instruction from IF/ID
//   instr_ready_o                 - stage accepts instr_i this cycle
//   flush_i                       - drop held entry and any same-cycle accept
//   ex_ready_i, ex_valid_o        - handshake towards execute
//   reg_write_en_o .. illegal_o   - registered control bundle
//   rd_o, rs1_o, rs2_o            - registered register indices
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter bit M_EXT    = 1'b1,
  parameter int ALU_OP_W = 5,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         instr_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                ex_valid_o,
  output logic                reg_write_en_o,
  output logic [1:0]          wb_sel_o,
  output logic                rs1_pc_sel_o,
  output logic                rs2_imm_sel_o,
  output logic [2:0]          imm_type_o,
  output logic                is_branch_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                uncond_branch_o,
  output logic                is_muldiv_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic                illegal_o
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  ctrl_t      decCtrl;
  logic [4:0] decRd;
  logic [4:0] decRs1;
  logic [4:0] decRs2;

  ctrl_t      ctrl_q;
  logic [4:0] rd_q;
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  logic       exValid_q;
  logic       exValid_d;
  logic [CNT_W-1:0] busyCnt_q;
  logic [CNT_W-1:0] busyCnt_d;
  logic       accept;

  instr_decoder #(
    .M_EXT(M_EXT)
  ) u_decoder (
    .instr_i(instr_i),
    .ctrl_o (decCtrl),
    .rd_o   (decRd),
    .rs1_o  (decRs1),
    .rs2_o  (decRs2)
  );

  assign instr_ready_o = (!exValid_q || ex_ready_i) && (busyCnt_q == '0);
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  // Flush wins over everything; otherwise an accept refills the register and
  // a consume without refill empties it.
  always_comb begin
    exValid_d = exValid_q;
    if (flush_i) begin
      exValid_d = 1'b0;
    end else if (accept) begin
      exValid_d = 1'b1;
    end else if (ex_ready_i) begin
      exValid_d = 1'b0;
    end
  end

  // Accept only happens with the counter at zero, so loading and counting
  // down never collide. funct3[2] splits MUL* from DIV/REM.
  always_comb begin
    busyCnt_d = busyCnt_q;
    if (flush_i) begin
      busyCnt_d = '0;
    end else if (accept && decCtrl.isMuldiv) begin
      busyCnt_d = instr_i[14] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end else if (busyCnt_q != '0) begin
      busyCnt_d = busyCnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exValid_q <= 1'b0;
      busyCnt_q <= '0;
    end else begin
      exValid_q <= exValid_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  // Payload only moves on accept, which keeps it stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (accept) begin
      ctrl_q <= decCtrl;
      rd_q   <= decRd;
      rs1_q  <= decRs1;
      rs2_q  <= decRs2;
    end
  end

  assign ex_valid_o      = exValid_q;
  assign reg_write_en_o  = ctrl_q.regWrite;
  assign wb_sel_o        = ctrl_q.wbSel;
  assign rs1_pc_sel_o    = ctrl_q.rs1PcSel;
  assign rs2_imm_sel_o   = ctrl_q.rs2ImmSel;
  assign imm_type_o      = ctrl_q.immType;
  assign is_branch_o     = ctrl_q.isBranch;
  assign is_load_o       = ctrl_q.isLoad;
  assign is_store_o      = ctrl_q.isStore;
  assign uncond_branch_o = ctrl_q.uncondBranch;
  assign is_muldiv_o     = ctrl_q.isMuldiv;
  assign alu_op_o        = ALU_OP_W'(ctrl_q.aluOp);
  assign illegal_o       = ctrl_q.illegal;
  assign rd_o            = rd_q;
  assign rs1_o           = rs1_q;
  assign rs2_o           = rs2_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: table-driven decode vectors on an RV32M
// instance plus hand sequences for busy stall, flush, backpressure and an
// RV32I-only instance.
module tb_decode_ctrl_stage;

  logic        clk;
  logic        rstN;
  logic [31:0] instr;
  logic        instrValid;
  logic        flush;
  logic        exReady;

  // RV32M instance outputs
  logic        ready, exValid, regWrite, rs1Pc, rs2Imm, isBranch, isLoad, isStore, uncond, isMuldiv, illegal;
  logic [1:0]  wbSel;
  logic [2:0]  immType;
  logic [4:0]  aluOp, rd, rs1, rs2;

  // RV32I-only instance outputs
  logic        nReady, nExValid, nRegWrite, nRs1Pc, nRs2Imm, nIsBranch, nIsLoad, nIsStore, nUncond, nIsMuldiv, nIllegal;
  logic [1:0]  nWbSel;
  logic [2:0]  nImmType;
  logic [3:0]  nAluOp;
  logic [4:0]  nRd, nRs1, nRs2;

  int passCount  = 0;
  int checkCount = 0;

  decode_ctrl_stage #(.M_EXT(1'b1), .ALU_OP_W(5), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk_i(clk), .rst_ni(rstN), .instr_i(instr), .instr_valid_i(instrValid),
    .instr_ready_o(ready), .flush_i(flush), .ex_ready_i(exReady), .ex_valid_o(exValid),
    .reg_write_en_o(regWrite), .wb_sel_o(wbSel), .rs1_pc_sel_o(rs1Pc), .rs2_imm_sel_o(rs2Imm),
    .imm_type_o(immType), .is_branch_o(isBranch), .is_load_o(isLoad), .is_store_o(isStore),
    .uncond_branch_o(uncond), .is_muldiv_o(isMuldiv), .alu_op_o(aluOp),
    .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .illegal_o(illegal)
  );

  decode_ctrl_stage #(.M_EXT(1'b0), .ALU_OP_W(4), .MUL_LAT(3), .DIV_LAT(33)) dutNoM (
    .clk_i(clk), .rst_ni(rstN), .instr_i(instr), .instr_valid_i(instrValid),
    .instr_ready_o(nReady), .flush_i(flush), .ex_ready_i(exReady), .ex_valid_o(nExValid),
    .reg_write_en_o(nRegWrite), .wb_sel_o(nWbSel), .rs1_pc_sel_o(nRs1Pc), .rs2_imm_sel_o(nRs2Imm),
    .imm_type_o(nImmType), .is_branch_o(nIsBranch), .is_load_o(nIsLoad), .is_store_o(nIsStore),
    .uncond_branch_o(nUncond), .is_muldiv_o(nIsMuldiv), .alu_op_o(nAluOp),
    .rd_o(nRd), .rs1_o(nRs1), .rs2_o(nRs2), .illegal_o(nIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  bundle;
    logic [3:0]  flags;
    logic        md;
    logic [4:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  localparam logic [7:0] B_LOAD = 8'b1_01_0_1_100;
  localparam logic [7:0] B_ST   = 8'b0_00_0_1_010;
  localparam logic [7:0] B_R    = 8'b1_00_0_0_000;
  localparam logic [7:0] B_I    = 8'b1_00_0_1_100;
  localparam logic [7:0] B_BR   = 8'b0_00_1_1_011;
  localparam logic [7:0] B_JALR = 8'b1_10_0_1_100;
  localparam logic [7:0] B_JAL  = 8'b1_10_1_1_001;
  localparam logic [7:0] B_LUI  = 8'b1_00_0_1_000;
  localparam logic [7:0] B_AUI  = 8'b1_00_1_1_000;

  // {branch, load, store, uncond}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_BR   = 4'b1000;
  localparam logic [3:0] F_LD   = 4'b0100;
  localparam logic [3:0] F_ST   = 4'b0010;
  localparam logic [3:0] F_UNC  = 4'b0001;

  function automatic vec_t mk(input logic [31:0] i, input logic [7:0] b, input logic [3:0] f,
                              input logic m, input logic [4:0] a, input logic il);
    vec_t v;
    v.instr = i; v.bundle = b; v.flags = f; v.md = m; v.alu = a; v.ill = il;
    return v;
  endfunction

  function automatic vec_t bad(input logic [31:0] i);
    return mk(i, 8'h00, F_NONE, 1'b0, 5'd0, 1'b1);
  endfunction

  // Expected registered control word with ex_valid set
  function automatic logic [19:0] expCtrl(input logic [7:0] b, input logic [3:0] f,
                                          input logic m, input logic [4:0] a, input logic il);
    return {1'b1, b, f, m, a, il};
  endfunction

  function automatic logic [19:0] actCtrl();
    return {exValid, regWrite, wbSel, rs1Pc, rs2Imm, immType,
            isBranch, isLoad, isStore, uncond, isMuldiv, aluOp, illegal};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for the RV32M instance to be ready, then presents one
  // instruction for a single edge. Returns at edge+1 with valid dropped.
  task automatic applyStimulus(input logic [31:0] word);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) checkOutput("ready timeout", 32'(ready), 32'd1);
    instr      = word;
    instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;

    vecs.push_back(mk(32'h002081B3, B_R,    F_NONE, 1'b0, 5'd0,  1'b0)); // ADD
    vecs.push_back(mk(32'h402081B3, B_R,    F_NONE, 1'b0, 5'd1,  1'b0)); // SUB
    vecs.push_back(mk(32'h4020D1B3, B_R,    F_NONE, 1'b0, 5'd7,  1'b0)); // SRA
    vecs.push_back(mk(32'h0020F1B3, B_R,    F_NONE, 1'b0, 5'd9,  1'b0)); // AND
    vecs.push_back(mk(32'h0020B1B3, B_R,    F_NONE, 1'b0, 5'd4,  1'b0)); // SLTU
    vecs.push_back(bad(32'h402091B3));                                   // SLL w/ 0100000
    vecs.push_back(bad(32'h802081B3));                                   // funct7 1000000
    vecs.push_back(mk(32'hFFF08293, B_I,    F_NONE, 1'b0, 5'd0,  1'b0)); // ADDI
    vecs.push_back(mk(32'h4030D293, B_I,    F_NONE, 1'b0, 5'd7,  1'b0)); // SRAI
    vecs.push_back(mk(32'h0030D293, B_I,    F_NONE, 1'b0, 5'd6,  1'b0)); // SRLI
    vecs.push_back(bad(32'h40309293));                                   // SLLI funct7!=0
    vecs.push_back(bad(32'h0230D293));                                   // SRLI funct7 0000001
    vecs.push_back(mk(32'h0000A283, B_LOAD, F_LD,   1'b0, 5'd0,  1'b0)); // LW
    vecs.push_back(mk(32'h0000C283, B_LOAD, F_LD,   1'b0, 5'd0,  1'b0)); // LBU
    vecs.push_back(bad(32'h0000B283));                                   // load f3 011
    vecs.push_back(bad(32'h0000E283));                                   // load f3 110
    vecs.push_back(mk(32'h0020A023, B_ST,   F_ST,   1'b0, 5'd0,  1'b0)); // SW
    vecs.push_back(bad(32'h0020B023));                                   // store f3 011
    vecs.push_back(mk(32'h00208063, B_BR,   F_BR,   1'b0, 5'd0,  1'b0)); // BEQ
    vecs.push_back(mk(32'h0020F063, B_BR,   F_BR,   1'b0, 5'd0,  1'b0)); // BGEU
    vecs.push_back(bad(32'h0020A063));                                   // branch f3 010
    vecs.push_back(mk(32'h000000EF, B_JAL,  F_UNC,  1'b0, 5'd0,  1'b0)); // JAL
    vecs.push_back(mk(32'h000100E7, B_JALR, F_UNC,  1'b0, 5'd0,  1'b0)); // JALR
    vecs.push_back(bad(32'h000110E7));                                   // JALR f3 001
    vecs.push_back(mk(32'h123452B7, B_LUI,  F_NONE, 1'b0, 5'd10, 1'b0)); // LUI
    vecs.push_back(mk(32'h00000297, B_AUI,  F_NONE, 1'b0, 5'd0,  1'b0)); // AUIPC
    vecs.push_back(bad(32'h00000000));                                   // all-zero
    vecs.push_back(bad(32'h00000031));                                   // bits[1:0]!=11
    vecs.push_back(mk(32'h022081B3, B_R,    F_NONE, 1'b1, 5'd11, 1'b0)); // MUL
    vecs.push_back(mk(32'h0220B1B3, B_R,    F_NONE, 1'b1, 5'd14, 1'b0)); // MULHU
    vecs.push_back(mk(32'h0220D1B3, B_R,    F_NONE, 1'b1, 5'd16, 1'b0)); // DIVU
    vecs.push_back(mk(32'h0220F1B3, B_R,    F_NONE, 1'b1, 5'd18, 1'b0)); // REMU

    rstN = 1'b1; instr = '0; instrValid = 1'b0; flush = 1'b0; exReady = 1'b1;
    #2 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", {12'd0, actCtrl()}, 32'd0);
    checkOutput("reset regs", {17'd0, rd, rs1, rs2}, 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("ready after reset", 32'(ready), 32'd1);

    $display("[TB] decode table");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].instr);
      checkOutput($sformatf("ctrl %h", vecs[k].instr), {12'd0, actCtrl()},
                  {12'd0, expCtrl(vecs[k].bundle, vecs[k].flags, vecs[k].md, vecs[k].alu, vecs[k].ill)});
      checkOutput($sformatf("regs %h", vecs[k].instr), {17'd0, rd, rs1, rs2},
                  {17'd0, vecs[k].instr[11:7], vecs[k].instr[19:15], vecs[k].instr[24:20]});
    end

    $display("[TB] DIV busy stall");
    applyStimulus(32'h0220C1B3);
    checkOutput("div ctrl", {12'd0, actCtrl()}, {12'd0, expCtrl(B_R, F_NONE, 1'b1, 5'd15, 1'b0)});
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    checkOutput("div stall cycles", 32'(cnt), 32'd32);

    $display("[TB] DIV flushed mid-stall");
    applyStimulus(32'h0220C1B3);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("busy before flush", 32'(ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("ready after flush", 32'(ready), 32'd1);
    checkOutput("valid after flush", 32'(exValid), 32'd0);

    $display("[TB] RV32I-only instance");
    applyStimulus(32'h022081B3);
    checkOutput("noM mul", {24'd0, nExValid, nIllegal, nRegWrite, nIsMuldiv, nAluOp},
                {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    applyStimulus(32'h00000000);
    checkOutput("noM zero", {24'd0, nExValid, nIllegal, nRegWrite, nIsMuldiv, nAluOp},
                {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    applyStimulus(32'h402081B3);
    checkOutput("noM sub", {24'd0, nExValid, nIllegal, nRegWrite, nIsMuldiv, nAluOp},
                {24'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1});

    $display("[TB] backpressure");
    applyStimulus(32'h00000013);
    @(posedge clk); #1;
    exReady = 1'b0;
    applyStimulus(32'h0000A283);
    instr      = 32'h002081B3;
    instrValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("lw held %0d", c), {12'd0, actCtrl()},
                  {12'd0, expCtrl(B_LOAD, F_LD, 1'b0, 5'd0, 1'b0)});
      checkOutput($sformatf("stalled ready %0d", c), 32'(ready), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("lw rd held", 32'(rd), 32'd5);
    exReady = 1'b1;
    #1;
    checkOutput("ready on consume", 32'(ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("back-to-back add", {12'd0, actCtrl()}, {12'd0, expCtrl(B_R, F_NONE, 1'b0, 5'd0, 1'b0)});
    instr = 32'h402081B3;
    @(posedge clk); #1;
    checkOutput("back-to-back sub", {12'd0, actCtrl()}, {12'd0, expCtrl(B_R, F_NONE, 1'b0, 5'd1, 1'b0)});
    instrValid = 1'b0;

    $display("[TB] flush with valid");
    @(posedge clk); #1;
    instr      = 32'h002081B3;
    instrValid = 1'b1;
    flush      = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    flush      = 1'b0;
    checkOutput("flush drops accept", 32'(exValid), 32'd0);

    $display("[TB] flush held entry");
    exReady = 1'b0;
    applyStimulus(32'h002081B3);
    checkOutput("held before flush", 32'(exValid), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("held entry flushed", 32'(exValid), 32'd0);
    exReady = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
